// File: rtl/dma_pkg.sv
// dma_pkg: definitions shared by the multi-channel DMA master.
// Contents:
//   - register offsets inside one channel's 4-word window;
//   - CTRL bit positions;
//   - the transfer FSM state encoding;
//   - an index-width helper that stays legal for a single channel.
package dma_pkg;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_BUSY  = 1;
  localparam int CTRL_DONE  = 2;
  localparam int CTRL_IRQEN = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // Width of a channel index; one bit minimum so NCH=1 still has a signal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dma_rr_arbiter.sv
// dma_rr_arbiter: combinational round-robin pick among pending channels.
// Ports:
//   pending_i  NCH-bit vector of channels with work outstanding.
//   last_i     index of the channel served most recently.
//   grant_o    one-hot selection.
//   idx_o      index of the selection.
//   valid_o    high when any channel is pending.
// The search starts at last_i+1 and wraps from NCH-1 to 0. The pointer register
// itself lives in the parent.
module dma_rr_arbiter
  import dma_pkg::*;
#(
  parameter  int NCH = 2,
  localparam int IW  = idx_w(NCH)
) (
  input  logic [NCH-1:0] pending_i,
  input  logic [IW-1:0]  last_i,
  output logic [NCH-1:0] grant_o,
  output logic [IW-1:0]  idx_o,
  output logic           valid_o
);

  logic [IW-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NCH; k++) begin
      cand = IW'((int'(last_i) + k) % NCH);
      if (!valid_o && pending_i[cand]) begin
        valid_o       = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/dma_master.sv
// dma_master: multi-channel memory-to-memory bus master with a CPU register port.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset.
//   S_sel/S_wr/S_addr  CPU register port.
//   S_din/S_dout       CPU register port data; S_dout is registered.
//                      S_addr = {channel, reg}.
//   op_clear           clears every done flag, and with it the interrupt.
//   M_req/M_grant      bus handshake; a word moves when both are high.
//   M_wr/M_address     bus direction and address.
//   M_dout/M_din       bus write and read data.
//   m_interrupt        registered OR of done & irq_en over all channels.
//
// Each word is one READ into an internal buffer, then one WRITE of that buffer.
// Arbitration is redone between words, so busy channels interleave word by word.
module dma_master
  import dma_pkg::*;
#(
  parameter  int AW  = 8,
  parameter  int DW  = 32,
  parameter  int NCH = 2,
  parameter  int LW  = 8,
  localparam int IW  = idx_w(NCH),
  localparam int SAW = $clog2(NCH) + 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           S_sel,
  input  logic           S_wr,
  input  logic [SAW-1:0] S_addr,
  input  logic [DW-1:0]  S_din,
  output logic [DW-1:0]  S_dout,
  input  logic           op_clear,
  output logic           M_req,
  input  logic           M_grant,
  output logic           M_wr,
  output logic [AW-1:0]  M_address,
  output logic [DW-1:0]  M_dout,
  input  logic [DW-1:0]  M_din,
  output logic           m_interrupt
);

  // Descriptor and status state, one entry per channel.
  logic [AW-1:0]  src_q [NCH];
  logic [AW-1:0]  src_d [NCH];
  logic [AW-1:0]  dst_q [NCH];
  logic [AW-1:0]  dst_d [NCH];
  logic [LW-1:0]  len_q [NCH];
  logic [LW-1:0]  len_d [NCH];
  logic [LW-1:0]  idx_q [NCH];
  logic [LW-1:0]  idx_d [NCH];
  logic [NCH-1:0] busy_q, busy_d;
  logic [NCH-1:0] done_q, done_d;
  logic [NCH-1:0] irq_en_q, irq_en_d;
  logic [NCH-1:0] done_set;

  // Transfer engine state.
  state_e         state_q, state_d;
  logic [IW-1:0]  cur_q, cur_d;
  logic [IW-1:0]  last_q, last_d;
  logic [DW-1:0]  buf_q, buf_d;
  logic [DW-1:0]  s_dout_q, s_dout_d;
  logic           irq_q;

  logic [IW-1:0]  s_ch;
  logic           s_wr_en;
  logic           s_rd_en;
  logic           last_word;
  logic [NCH-1:0] arb_grant_unused;
  logic [IW-1:0]  arb_idx;
  logic           arb_valid;
  logic           unused_din;

  // Only the low bits of S_din reach any register.
  assign unused_din = ^S_din;

  generate
    if (NCH > 1) begin : g_ch_field
      assign s_ch = S_addr[SAW-1:2];
    end else begin : g_one_ch
      assign s_ch = '0;
    end
  endgenerate

  assign s_wr_en = S_sel && S_wr;
  assign s_rd_en = S_sel && !S_wr;

  // The word being written is the last one when idx+1 reaches LEN.
  // Both sides are widened by one bit so idx+1 cannot wrap.
  assign last_word = ({1'b0, idx_q[cur_q]} + (LW+1)'(1)) == {1'b0, len_q[cur_q]};

  dma_rr_arbiter #(.NCH(NCH)) u_arb (
    .pending_i (busy_q),
    .last_i    (last_q),
    .grant_o   (arb_grant_unused),
    .idx_o     (arb_idx),
    .valid_o   (arb_valid)
  );

  always_comb begin
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = done_q;
    irq_en_d = irq_en_q;
    done_set = '0;
    state_d  = state_q;
    cur_d    = cur_q;
    last_d   = last_q;
    buf_d    = buf_q;
    s_dout_d = s_dout_q;

    M_req     = 1'b0;
    M_wr      = 1'b0;
    M_address = '0;
    M_dout    = '0;

    // CPU writes. The descriptor of a busy channel is frozen.
    if (s_wr_en) begin
      case (S_addr[1:0])
        REG_SRC: if (!busy_q[s_ch]) src_d[s_ch] = S_din[AW-1:0];
        REG_DST: if (!busy_q[s_ch]) dst_d[s_ch] = S_din[AW-1:0];
        REG_LEN: if (!busy_q[s_ch]) len_d[s_ch] = S_din[LW-1:0];
        REG_CTRL: begin
          irq_en_d[s_ch] = S_din[CTRL_IRQEN];
          if (S_din[CTRL_DONE]) done_d[s_ch] = 1'b0;
          if (S_din[CTRL_START] && !busy_q[s_ch]) begin
            if (len_q[s_ch] == '0) begin
              done_set[s_ch] = 1'b1;
            end else begin
              busy_d[s_ch] = 1'b1;
              idx_d[s_ch]  = '0;
              done_d[s_ch] = 1'b0;
            end
          end
        end
      endcase
    end

    // CPU reads, captured into the registered read port.
    if (s_rd_en) begin
      case (S_addr[1:0])
        REG_SRC:  s_dout_d = DW'(src_q[s_ch]);
        REG_DST:  s_dout_d = DW'(dst_q[s_ch]);
        REG_LEN:  s_dout_d = DW'(len_q[s_ch]);
        REG_CTRL: s_dout_d = DW'({irq_en_q[s_ch], done_q[s_ch], busy_q[s_ch], 1'b0});
      endcase
    end

    if (op_clear) done_d = '0;

    // Bus engine. Outputs come only from registered state, so they cannot
    // change while a request waits for its grant.
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          cur_d   = arb_idx;
          last_d  = arb_idx;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        M_req     = 1'b1;
        M_address = src_q[cur_q] + AW'(idx_q[cur_q]);
        if (M_grant) begin
          buf_d   = M_din;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        M_req     = 1'b1;
        M_wr      = 1'b1;
        M_address = dst_q[cur_q] + AW'(idx_q[cur_q]);
        M_dout    = buf_q;
        if (M_grant) begin
          idx_d[cur_q] = idx_q[cur_q] + LW'(1);
          if (last_word) begin
            busy_d[cur_q]   = 1'b0;
            done_set[cur_q] = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Setting done is applied last, so it overrides op_clear and write-1-to-clear.
    done_d = done_d | done_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      last_q   <= IW'(NCH - 1);
      buf_q    <= '0;
      s_dout_q <= '0;
      irq_q    <= 1'b0;
      busy_q   <= '0;
      done_q   <= '0;
      irq_en_q <= '0;
      // NOTE: the descriptor arrays are reset too, because software-visible readback must show 0.
      for (int i = 0; i < NCH; i++) begin
        src_q[i] <= '0;
        dst_q[i] <= '0;
        len_q[i] <= '0;
        idx_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments only; every register samples _d from the same edge.
      state_q  <= state_d;
      cur_q    <= cur_d;
      last_q   <= last_d;
      buf_q    <= buf_d;
      s_dout_q <= s_dout_d;
      irq_q    <= |(done_q & irq_en_q);
      busy_q   <= busy_d;
      done_q   <= done_d;
      irq_en_q <= irq_en_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
    end
  end

  assign S_dout      = s_dout_q;
  assign m_interrupt = irq_q;

endmodule

// File: doc/dma_master.md
# dma_master

Parametrised multi-channel bus master: the next generation of the single-channel course-project master. A slave-side register port lets a CPU program up to NCH copy descriptors (source, destination, length). The block then moves words across the shared bus using a req/grant handshake, with round-robin arbitration between channels. It raises a level interrupt on completion. It sits between the bus arbiter (master port 1) and the CPU register bus.

## Interface
Parameters:
- AW, 8: bus address width; address arithmetic wraps modulo 2^AW.
- DW, 32: bus data width.
- NCH, 2: channel count, power of two, 1..4.
- LW, 8: length field width, in words.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- S_sel  in  1  register-port select.
- S_wr  in  1  1 = write, 0 = read; qualified by S_sel.
- S_addr  in  log2(NCH)+2  register address: channel = S_addr[MSB:2], reg = S_addr[1:0].
- S_din  in  DW  register write data.
- S_dout  out  DW  register read data, registered.
- op_clear  in  1  clears all done flags and the interrupt.
- M_req  out  1  bus request.
- M_grant  in  1  transfer completes in any cycle where M_req && M_grant.
- M_wr  out  1  1 = bus write, 0 = bus read.
- M_address  out  AW  bus address.
- M_dout  out  DW  bus write data.
- M_din  in  DW  bus read data, valid in the grant cycle.
- m_interrupt  out  1  level interrupt, registered.

## Operation
- Per-channel registers:
  - 0 SRC[AW-1:0].
  - 1 DST[AW-1:0].
  - 2 LEN[LW-1:0].
  - 3 CTRL: bit0 start (write-1, self-clearing, reads 0), bit1 busy (RO), bit2 done (sticky, write-1-to-clear), bit3 irq_en.
  - Unused bits read 0.
- Writes to SRC/DST/LEN of a busy channel are ignored. A start write to a busy channel is ignored.
- Start with LEN=0 sets done on the next cycle with no bus traffic.
- Start with LEN>0 sets busy and clears both the word index and done.
- FSM states: IDLE, READ, WRITE.
  - IDLE: pick the first busy channel after the last-served one (round-robin, wrap at NCH-1 to 0), then go to READ. If none is busy, stay in IDLE.
  - READ: M_req=1, M_wr=0, M_address=SRC+idx. On grant, latch M_din into a DW buffer and go to WRITE.
  - WRITE: M_req=1, M_wr=1, M_address=DST+idx, M_dout=buffer. On grant, idx++.
    - If idx+1 == LEN: clear busy, set done.
    - In both cases, return to IDLE. Channels re-arbitrate every word.
- M_req stays high until grant; M_address, M_wr and M_dout are stable while waiting.
- m_interrupt = registered OR over channels of (done & irq_en).
- op_clear clears every done flag. If op_clear coincides with a done-set in the same cycle, the set wins.
- A CPU write-1-to-clear on done coincident with a done-set: the set wins.
- Reset mid-transfer aborts all channels. No partial word is written after reset.

## Timing
- Reset values:
  - S_dout=0, M_req=0, M_wr=0, M_address=0, M_dout=0, m_interrupt=0.
  - All registers 0; FSM in IDLE; round-robin pointer set to NCH-1 (channel 0 is served first).
- Register read latency: 1 cycle. S_dout updates the cycle after S_sel && !S_wr and holds until the next read.
- Start to first M_req: 2 cycles (start registered, then IDLE arbitration).
- Per word with immediate grant: 3 cycles (IDLE, READ, WRITE).
- done and busy update on the edge ending the final write grant. m_interrupt rises 1 cycle later.
- op_clear drops m_interrupt 2 cycles after assertion: done clears on the next edge, then the registered interrupt follows.

## Structure
- Shared package dma_pkg: register offsets (REG_SRC=0, REG_DST=1, REG_LEN=2, REG_CTRL=3), CTRL bit positions, FSM state encoding.
- One sub-module, dma_rr_arbiter: NCH-bit pending vector plus last-served pointer in, one-hot grant and index out. Purely combinational, with the pointer register kept in the parent.

## Test plan
- Reset: drive reset for 2 cycles mid-copy. All outputs are 0 on the following edge, and M_req stays 0 until a new start.
- Single copy, channel 0: SRC=0x10, DST=0x80, LEN=3, irq_en=1, grant tied high.
  - Bus sequence: R10, W80, R11, W81, R12, W82, 9 cycles total.
  - m_interrupt rises 1 cycle after the final write grant.
- Two channels both started in the same cycle: ch0 SRC=0x00/DST=0x40/LEN=2, ch1 SRC=0x20/DST=0x60/LEN=2. Transfers alternate ch0, ch1, ch0, ch1 by word.
- Wait states: hold M_grant low for 4 cycles on the read. M_address=SRC and M_wr=0 remain stable, and the data is latched only in the grant cycle.
- Wrap-around and zero length:
  - SRC=0xFE, LEN=3 reads addresses 0xFE, 0xFF, 0x00.
  - LEN=0 with start sets done with no M_req.
- Clear races: op_clear asserted in the same cycle as the final write grant leaves done=1. op_clear on the next cycle clears it, and m_interrupt falls 2 cycles later. A write of SRC while busy is ignored (readback shows the old value).
